// File: rtl/apb_ram_completer.sv
// APB4 completer backed by a word-addressed register RAM.
// Adds programmable wait states, honours PSTRB on writes and flags faults on PSLVERR.
// Ports: PCLK/PRESET (async, active-high); APB inputs PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA, PSTRB, PPROT; outputs PREADY, PRDATA, PSLVERR.
module apb_ram_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic                  PREADY,
  output logic [31:0]           PRDATA,
  output logic                  PSLVERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [AW-1:0] idx;
  logic        wr;
  logic [3:0]  strb;
  logic        err;
  logic [31:0] mem [DEPTH];

  logic        setup;
  logic        done;
  logic        wr_en;
  logic        err_in;
  logic [AW-1:0] idx_in;
  logic        unused_prot;

  assign unused_prot = ^PPROT[2:1];

  assign idx_in = PADDR[AW+1:2];

  // Word 0 is a control word only privileged writers may touch.
  assign err_in = (PADDR[1:0] != 2'b00)
               || ({1'b0, PADDR} >= LIMIT)
               || (!PWRITE && (PSTRB != 4'h0))
               || (PWRITE && !PPROT[0] && (idx_in == '0));

  assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
  assign PSLVERR = PREADY && err;
  assign PRDATA  = (PREADY && !wr && !err) ? mem[idx] : 32'h0;

  assign done  = PREADY && PSEL && PENABLE;
  assign wr_en = done && wr && !err;

  always_comb begin
    state_nxt = state;
    setup     = 1'b0;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL || done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= '0;
      wr    <= 1'b0;
      strb  <= 4'h0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      state <= state_nxt;
      if (setup) begin
        cnt  <= 4'(WAIT_CYCLES);
        idx  <= idx_in;
        wr   <= PWRITE;
        strb <= PSTRB;
        err  <= err_in;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (wr_en) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_completer.sv
// Directed testbench for apb_ram_completer.
// Two instances share the bus: PSEL0 -> 2 wait states, PSEL1 -> 0 wait states.
module tb_apb_ram_completer;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        ready0, ready1, slverr0, slverr1;
  logic [31:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_ram_completer #(.ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PREADY(ready0), .PRDATA(rdata0), .PSLVERR(slverr0)
  );

  apb_ram_completer #(.ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel1), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PREADY(ready1), .PRDATA(rdata1), .PSLVERR(slverr1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int which);
    return which ? ready1 : ready0;
  endfunction

  // Starts at a negedge; returns at the negedge after the completion edge
  // with the bus idle, so a following call gives zero idle cycles.
  task automatic xfer(input int which, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, output logic [31:0] rd,
                      output logic err, output int cyc);
    int n;
    psel0   = (which == 0);
    psel1   = (which == 1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    pprot   = p;
    @(negedge clk);
    penable = 1'b1;
    n = 1;
    while (!rdy(which) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("timeout", 32'(n), 32'd0);
    rd  = which ? rdata1 : rdata0;
    err = which ? slverr1 : slverr0;
    cyc = n + 1;
    @(negedge clk);
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        e;
  int          cyc;

  initial begin
    rst = 1'b1;
    psel0 = 0; psel1 = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    #1;
    check("rst_ready", {31'd0, ready0}, 32'd0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_slverr", {31'd0, slverr0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, e, cyc);
    check("wr4_len", 32'(cyc), 32'd4);
    check("wr4_err", {31'd0, e}, 32'd0);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("rd4_len", 32'(cyc), 32'd4);
    check("rd4_data", rd, 32'hDEADBEEF);
    check("rd4_err", {31'd0, e}, 32'd0);

    xfer(0, 1, 32'h08, 32'h11223344, 4'hF, 3'b001, rd, e, cyc);
    xfer(0, 1, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b001, rd, e, cyc);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("strb_data", rd, 32'h11BB33DD);

    xfer(0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b001, rd, e, cyc);
    check("oob_err", {31'd0, e}, 32'd1);
    check("oob_len", 32'(cyc), 32'd4);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("oob_ram", rd, 32'h0);

    xfer(0, 1, 32'h06, 32'hFFFFFFFF, 4'hF, 3'b001, rd, e, cyc);
    check("mis_err", {31'd0, e}, 32'd1);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("mis_ram", rd, 32'hDEADBEEF);

    xfer(0, 0, 32'h04, 32'h0, 4'h1, 3'b001, rd, e, cyc);
    check("rdstrb_err", {31'd0, e}, 32'd1);
    check("rdstrb_data", rd, 32'h0);

    xfer(0, 1, 32'h00, 32'h12345678, 4'hF, 3'b000, rd, e, cyc);
    check("priv_err", {31'd0, e}, 32'd1);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("priv_ram", rd, 32'h0);
    xfer(0, 1, 32'h00, 32'h12345678, 4'hF, 3'b001, rd, e, cyc);
    check("priv_ok", {31'd0, e}, 32'd0);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("priv_data", rd, 32'h12345678);

    // Abort: drop PSEL in the first access cycle.
    psel0 = 1; penable = 0; pwrite = 1; paddr = 32'h08;
    pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    psel0 = 0; penable = 1;
    @(negedge clk);
    penable = 0;
    check("abort_ready", {31'd0, ready0}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_ready2", {31'd0, ready0}, 32'd0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("abort_ram", rd, 32'h11BB33DD);

    // PSEL+PENABLE with no setup phase must be ignored.
    psel0 = 1; penable = 1; pwrite = 1; paddr = 32'h08;
    pwdata = 32'h0; pstrb = 4'hF;
    @(negedge clk);
    check("viol_ready", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    check("viol_ready2", {31'd0, ready0}, 32'd0);
    psel0 = 0; penable = 0;
    @(negedge clk);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 3'b001, rd, e, cyc);
    check("viol_ram", rd, 32'h11BB33DD);

    // Reset while a read of 0x04 is presenting data.
    psel0 = 1; penable = 0; pwrite = 0; paddr = 32'h04; pstrb = 4'h0;
    @(negedge clk);
    penable = 1;
    repeat (2) @(negedge clk);
    check("pre_rst_ready", {31'd0, ready0}, 32'd1);
    check("pre_rst_data", rdata0, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, ready0}, 32'd0);
    check("mid_rst_data", rdata0, 32'h0);
    check("mid_rst_err", {31'd0, slverr0}, 32'd0);
    psel0 = 0; penable = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      xfer(0, 0, 32'(4 * i), 32'h0, 4'h0, 3'b001, rd, e, cyc);
      check($sformatf("rst_word%0d", i), rd, 32'h0);
    end

    // Zero-wait back-to-back on the second instance.
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1, 32'(4 * i), 32'hC0DE0000 + 32'(i * 17), 4'hF, 3'b001,
           rd, e, cyc);
      check($sformatf("b2b_wlen%0d", i), 32'(cyc), 32'd2);
      check($sformatf("b2b_werr%0d", i), {31'd0, e}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1, 0, 32'(4 * i), 32'h0, 4'h0, 3'b001, rd, e, cyc);
      check($sformatf("b2b_rlen%0d", i), 32'(cyc), 32'd2);
      check($sformatf("b2b_rdata%0d", i), rd, 32'hC0DE0000 + 32'(i * 17));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_ram_completer.md
# apb_ram_completer

APB4 completer (responder) that terminates transfers on one select line with a word-addressed register RAM. It inserts a programmable number of wait states, honours PSTRB byte lanes on writes, and reports protocol and address faults on PSLVERR. It attaches to the shared APB bus alongside the existing master and slave interfaces, driven by either PSEL0 or PSEL1 at the top level. It also serves as the bench reference responder for master-side testing.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DEPTH, 16, number of 32-bit words; power of two, 2..256
- WAIT_CYCLES, 2, wait states inserted per transfer; 0..15
- PCLK  in  1  clock, all state updates on rising edge
- PRESET  in  1  reset; asynchronous and active-high
- PSEL  in  1  select for this completer
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  32  write data
- PSTRB  in  4  write byte strobes; lane i = PWDATA[8i+7:8i]
- PPROT  in  3  protection; only PPROT[0] (privileged) is used
- PREADY  out  1  transfer completion
- PRDATA  out  32  read data
- PSLVERR  out  1  transfer error

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - An edge sampling PSEL=1, PENABLE=0 is a setup edge.
  - On a setup edge: capture PADDR, PWRITE, PSTRB, PPROT and the error flag; load wait counter = WAIT_CYCLES; go to ACCESS.
  - All other inputs: stay in IDLE.
- ACCESS:
  - While the counter ≠ 0, decrement it each edge.
  - PREADY = (state==ACCESS && counter==0); Moore output, no input paths.
  - Completion edge = ACCESS with PREADY=1 and PSEL=1 and PENABLE=1 sampled.
    - On a non-error write, update the RAM at the captured word index, byte lanes with PSTRB=1 only.
    - Go to IDLE.
  - If PSEL=0 is sampled in ACCESS, abort: go to IDLE with no RAM update.
- Word index = captured PADDR[log2(DEPTH)+1:2].
- Error flag is set if any of the following holds:
  - PADDR[1:0] ≠ 0;
  - PADDR ≥ 4*DEPTH;
  - read with PSTRB ≠ 0;
  - write with PPROT[0]=0 to word index 0, which is a privileged-only control word.
- An errored transfer completes with normal timing. An errored write leaves the RAM unchanged. An errored read returns PRDATA=0.
- PRDATA = RAM[index] when PREADY=1, captured PWRITE=0 and no error; otherwise 32'h0.
- PSLVERR = PREADY && error flag; 0 at all other times.
- PADDR, PWDATA, PSTRB changing during ACCESS are ignored, except PWDATA, which is sampled on the completion edge.

## Timing
- Reset (PRESET=1, asynchronous):
  - state=IDLE, counter=0, all RAM words=0;
  - PREADY=0, PRDATA=0, PSLVERR=0 immediately, without waiting for a PCLK edge.
- Reset asserted mid-transfer: transfer dropped, RAM retains no partial write. Deassertion is synchronous to the next edge.
- Transfer length = 2 + WAIT_CYCLES cycles from setup cycle to completion cycle inclusive. WAIT_CYCLES=0 gives PREADY high in the first access cycle.
- Write data is visible to a read whose setup edge follows the write's completion edge.
- Back-to-back transfers: a setup edge is accepted on the first IDLE edge after completion. The minimum gap is 0 idle cycles between completion and the next setup cycle.
- PREADY is low in every IDLE cycle, including any cycle where PSEL=1 and PENABLE=1 are sampled with no prior setup. That is a protocol violation: no state change, no RAM update.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x04 with PSTRB=4'hF and PPROT=3'b001, WAIT_CYCLES=2:
  - PREADY low for 2 access cycles, then high for 1;
  - PSLVERR=0;
  - read of 0x04 returns 32'hDEADBEEF in a 4-cycle transfer.
- Byte strobes: write 32'h11223344 to 0x08 with PSTRB=4'hF, then write 32'hAABBCCDD with PSTRB=4'b0101. Read of 0x08 returns 32'h11BB33DD.
- Errors, each with PSLVERR=1 on its completion cycle and RAM unchanged:
  - write to 0x40 with DEPTH=16;
  - write to 0x06;
  - read of 0x04 with PSTRB=4'h1 (also PRDATA=0);
  - write to 0x00 with PPROT[0]=0.
  - The same write to 0x00 with PPROT[0]=1 succeeds.
- Abort and reset:
  - Setup a write, then drop PSEL in the 1st access cycle: FSM returns to IDLE and the word is unchanged.
  - Assert PRESET mid-ACCESS: PREADY=0 immediately and all words read back 0.
- Back-to-back with WAIT_CYCLES=0:
  - 4 consecutive writes to 0x00–0x0C (PPROT=1), each 2 cycles with no idle gap;
  - then 4 reads, each returning the written data.
